// File: rtl/midi_uart_tx_driver.sv
// MIDI-out 8N1 UART transmitter with a small FIFO in front of the serialiser.
// Outputs are registered; ready depends only on reset and the registered occupancy.
module midi_uart_tx_driver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 31_250,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] data_out,
  input  logic                  data_out_valid,
  output logic                  data_out_ready,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("midi_uart_tx_driver: CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("midi_uart_tx_driver: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [BYTE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [BYTE_WIDTH-1:0] shift, shift_n;
  logic [IDX_W-1:0]      bit_idx, idx_n;
  logic [BAUD_W-1:0]     baud, baud_n;
  logic                  tx_n;
  logic                  push, pop;
  logic [BYTE_WIDTH-1:0] head;

  assign data_out_ready = !reset && (count < FULL);
  assign push           = data_out_valid && data_out_ready;
  assign head           = mem[rd_ptr];
  assign busy           = (state != IDLE) || (count != '0);

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_out;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      state   <= state_n;
      uart_tx <= tx_n;
      shift   <= shift_n;
      bit_idx <= idx_n;
      baud    <= baud_n;
    end
  end

  // The shift register moves right once per data bit, so the next bit is always shift[1].
  always_comb begin
    state_n = state;
    tx_n    = uart_tx;
    shift_n = shift;
    idx_n   = bit_idx;
    baud_n  = baud;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud == LAST_BAUD) begin
          baud_n  = '0;
          tx_n    = shift[0];
          idx_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud == LAST_BAUD) begin
          baud_n = '0;
          if (bit_idx == LAST_IDX) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            idx_n   = bit_idx + IDX_W'(1);
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud == LAST_BAUD) begin
          baud_n = '0;
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_midi_uart_tx_driver.sv
// Bench for midi_uart_tx_driver: a frame-level model (queue + position in frame)
// is compared with the small instance every cycle; a default-parameter instance checks real timing.
module tb_midi_uart_tx_driver;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_r, valid_r;
  logic [7:0] data_r;
  logic       ready, tx, busy;
  logic       reset_d, valid_d;
  logic [7:0] data_d;
  logic       ready_d, tx_d, busy_d;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [7:0] q[$];
  logic [7:0] popped[$];
  logic       active = 1'b0;
  int         pos = 0;
  logic [7:0] cur = 8'h00;

  logic cap_tx[200];
  logic cap_busy[200];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_uart_tx_driver #(
    .CLOCK_FREQ(16), .BAUD_RATE(4), .BYTE_WIDTH(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock_50_000_000(clk), .reset(reset_r), .data_out(data_r),
    .data_out_valid(valid_r), .data_out_ready(ready), .uart_tx(tx), .busy(busy)
  );

  midi_uart_tx_driver dut_def (
    .clock_50_000_000(clk), .reset(reset_d), .data_out(data_d),
    .data_out_valid(valid_d), .data_out_ready(ready_d), .uart_tx(tx_d), .busy(busy_d)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] d);
    @(posedge clk);
    #1;
    reset_r = rst;
    valid_r = vld;
    data_r  = d;
  endtask

  // One clock edge of the model: a frame is a byte plus a position 0..FRAME-1.
  task automatic model_step();
    logic accept;
    accept = valid_r && !reset_r && (q.size() < DEPTH);
    if (reset_r) begin
      q.delete();
      active = 1'b0;
      pos    = 0;
    end else begin
      if (active) begin
        if (pos == FRAME - 1) active = 1'b0;
        else pos++;
      end
      if (!active && q.size() > 0) begin
        cur    = q.pop_front();
        active = 1'b1;
        pos    = 0;
        popped.push_back(cur);
      end
      if (accept) q.push_back(data_r);
    end
  endtask

  function automatic int model_tx();
    int b;
    if (!active) return 1;
    b = pos / CPB;
    if (b == 0) return 0;
    if (b <= 8) return int'(cur[b-1]);
    return 1;
  endfunction

  initial begin
    @(posedge clk);
    model_step();
    forever begin
      @(negedge clk);
      checkOutput("tx", int'(tx), model_tx());
      checkOutput("busy", int'(busy), int'(active || q.size() != 0));
      checkOutput("ready", int'(ready), int'(!reset_r && q.size() < DEPTH));
      @(posedge clk);
      model_step();
    end
  end

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int done;
    done = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && tx === 1'b1) begin
        done = 1;
        break;
      end
    end
    checkOutput(name, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 1000000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [9:0] exp_bits;
    int first_low, busy_fall, b, n_acc, acc_drop, low_run, low_done, guard, r, lows;
    int fall, rise, idle;

    reset_r = 1'b1; valid_r = 1'b0; data_r = 8'h00;
    reset_d = 1'b1; valid_d = 1'b0; data_d = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ready", int'(ready), 0);
    @(posedge clk);
    #1;
    reset_r = 1'b0;
    reset_d = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", int'(ready), 1);

    // Single byte 0x90: start, bits 0,0,0,0,1,0,0,1, stop (LSB first)
    popped.delete();
    applyStimulus(0, 1, 8'h90);
    applyStimulus(0, 0, 8'h00);
    capture(48);
    first_low = -1; busy_fall = -1;
    for (int i = 0; i < 48; i++) begin
      if (first_low < 0 && cap_tx[i] == 1'b0) first_low = i;
      if (first_low >= 0 && busy_fall < 0 && cap_busy[i] == 1'b0) busy_fall = i;
    end
    checkOutput("t1_first_low", first_low, 1);
    checkOutput("t1_busy_span", busy_fall - first_low, 40);
    exp_bits = 10'b1_1001_0000_0;
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("t1_bit%0d", k), int'(cap_tx[1 + 4*k + 2]), int'(exp_bits[k]));

    // Three bytes back to back with no idle gap
    popped.delete();
    applyStimulus(0, 1, 8'h90);
    applyStimulus(0, 1, 8'h3C);
    applyStimulus(0, 1, 8'h7F);
    applyStimulus(0, 0, 8'h00);
    capture(130);
    checkOutput("t2_stop_before_2nd", int'(cap_tx[38]), 1);
    checkOutput("t2_start_of_2nd", int'(cap_tx[39]), 0);
    checkOutput("t2_start_of_3rd", int'(cap_tx[79]), 0);
    busy_fall = -1;
    for (int i = 0; i < 130; i++)
      if (busy_fall < 0 && cap_busy[i] == 1'b0) busy_fall = i;
    checkOutput("t2_busy_fall", busy_fall, 119);
    checkOutput("t2_count", popped.size(), 3);
    if (popped.size() == 3) begin
      checkOutput("t2_b0", int'(popped[0]), 'h90);
      checkOutput("t2_b1", int'(popped[1]), 'h3C);
      checkOutput("t2_b2", int'(popped[2]), 'h7F);
    end

    // Hold valid with bytes 1..8 and watch back-pressure
    popped.delete();
    b = 1; n_acc = 0; acc_drop = -1; low_run = 0; low_done = 0; guard = 0;
    applyStimulus(0, 1, 8'd1);
    while (b <= 8 && guard < 600) begin
      @(negedge clk);
      r = int'(ready);
      if (r == 0 && acc_drop < 0) acc_drop = n_acc;
      if (r == 0 && low_done == 0) low_run++;
      if (r == 1 && acc_drop >= 0) low_done = 1;
      @(posedge clk);
      #1;
      if (r == 1) begin
        n_acc++;
        b++;
      end
      if (b <= 8) data_r = 8'(b);
      else valid_r = 1'b0;
      guard++;
    end
    valid_r = 1'b0;
    checkOutput("t3_all_accepted", b, 9);
    checkOutput("t3_accepted_before_full", acc_drop, 5);
    checkOutput("t3_ready_low_cycles", low_run, 37);
    wait_idle("t3_drain", 500);
    checkOutput("t3_count", popped.size(), 8);
    if (popped.size() == 8)
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("t3_order%0d", i), int'(popped[i]), i + 1);

    // Reset in the middle of a data bit with two bytes queued
    popped.delete();
    applyStimulus(0, 1, 8'hA5);
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    applyStimulus(0, 0, 8'h00);
    repeat (8) @(posedge clk);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 0, 8'h00);
    @(negedge clk);
    checkOutput("t4_tx_after_reset", int'(tx), 1);
    checkOutput("t4_busy_after_reset", int'(busy), 0);
    checkOutput("t4_ready_after_reset", int'(ready), 1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    checkOutput("t4_no_frames", lows, 0);
    popped.delete();
    applyStimulus(0, 1, 8'h55);
    applyStimulus(0, 0, 8'h00);
    wait_idle("t4_drain", 100);
    checkOutput("t4_one_frame", popped.size(), 1);
    if (popped.size() == 1) checkOutput("t4_byte", int'(popped[0]), 'h55);

    // valid while reset is held
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 8'hAA);
      @(negedge clk);
      checkOutput("t5_ready", int'(ready), 0);
      checkOutput("t5_tx", int'(tx), 1);
    end
    applyStimulus(0, 0, 8'h00);
    @(negedge clk);
    checkOutput("t5_busy", int'(busy), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      applyStimulus(logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 2) == 0),
                    8'($urandom));
    applyStimulus(0, 0, 8'h00);
    wait_idle("rand_drain", 400);

    // Default parameters: 1600 clocks per bit
    @(posedge clk);
    #1;
    valid_d = 1'b1;
    data_d  = 8'hFE;
    @(posedge clk);
    #1;
    valid_d = 1'b0;
    fall = -1; rise = -1; idle = -1;
    for (int i = 0; i < 16100; i++) begin
      @(negedge clk);
      if (fall < 0 && tx_d == 1'b0) fall = i;
      if (fall >= 0 && rise < 0 && tx_d == 1'b1) rise = i;
      if (fall >= 0 && busy_d == 1'b0) begin
        idle = i;
        break;
      end
    end
    checkOutput("t6_first_low", fall, 1);
    checkOutput("t6_start_plus_bit0", rise - fall, 3200);
    checkOutput("t6_frame", idle - fall, 16000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
